// File: rtl/fc_layer_stream.sv
// One fully-connected layer: NUM_NEURONS parallel MAC lanes fed by a streamed
// input vector, followed by shift/ReLU/saturate and a backpressured serial output.
module fc_layer_stream #(
    parameter int IN_WIDTH    = 26,
    parameter int W_WIDTH     = 16,
    parameter int W_FRAC      = 12,
    parameter int OUT_WIDTH   = IN_WIDTH + 3,
    parameter int NUM_NEURONS = 10,
    parameter int PREV_COUNT  = 30,
    parameter int ACC_WIDTH   = IN_WIDTH + W_WIDTH + $clog2(PREV_COUNT) + 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   act_mode,
    input  logic                                                   start,
    input  logic                                                   restart,
    input  logic                                                   wt_valid,
    input  logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] wt_neuron,
    input  logic [((PREV_COUNT > 1) ? $clog2(PREV_COUNT) : 1)-1:0]   wt_addr,
    input  logic signed [W_WIDTH-1:0]                              wt_data,
    input  logic                                                   wt_last,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic signed [IN_WIDTH-1:0]                             in_data,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic signed [OUT_WIDTH-1:0]                            out_data,
    output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] out_index,
    output logic                                                   out_last,
    output logic                                                   layer_ready,
    output logic                                                   busy,
    output logic                                                   done
);

    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int CW = (PREV_COUNT > 1) ? $clog2(PREV_COUNT) : 1;
    localparam int PW = IN_WIDTH + W_WIDTH;

    localparam logic [CW-1:0] LAST_C = CW'(PREV_COUNT - 1);
    localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);
    localparam logic [CW:0]   C_LIM  = (CW + 1)'(PREV_COUNT);
    localparam logic [NW:0]   N_LIM  = (NW + 1)'(NUM_NEURONS);

    // Output range expressed in accumulator width so the clamp compares like with like.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ACTIV,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic signed [W_WIDTH-1:0]   wmem   [NUM_NEURONS][PREV_COUNT];
    logic signed [ACC_WIDTH-1:0] acc_q  [NUM_NEURONS];
    logic signed [PW-1:0]        prod   [NUM_NEURONS];
    logic signed [OUT_WIDTH-1:0] res_q  [NUM_NEURONS];
    logic signed [OUT_WIDTH-1:0] act_d  [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0] shv;

    logic [CW-1:0] cnt_q;
    logic [NW-1:0] oidx_q;
    logic          mode_q;

    logic start_go;
    logic in_hs;
    logic out_hs;
    logic wt_ok;
    logic wt_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // restart overrides everything and also suppresses any handshake in the same cycle
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        start_go  = 1'b0;
        in_hs     = 1'b0;
        out_hs    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && layer_ready) begin
                    state_d  = ACCUM;
                    start_go = 1'b1;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                in_hs    = in_valid;
                if (in_valid && (cnt_q == LAST_C)) begin
                    state_d = ACTIV;
                end
            end
            ACTIV: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_hs    = out_ready;
                if (out_ready && (oidx_q == LAST_N)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (restart) begin
            state_d   = IDLE;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            start_go  = 1'b0;
            in_hs     = 1'b0;
            out_hs    = 1'b0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_data  = res_q[oidx_q];
    assign out_index = oidx_q;
    assign out_last  = out_valid && (oidx_q == LAST_N);

    assign wt_ok = (state_q == IDLE) && wt_valid && !restart;
    assign wt_we = wt_ok && ({1'b0, wt_neuron} < N_LIM) && ({1'b0, wt_addr} < C_LIM);

    always_ff @(posedge clk) begin
        if (wt_we) begin
            wmem[wt_neuron][wt_addr] <= wt_data;
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            prod[n] = PW'(in_data) * PW'(wmem[n][cnt_q]);
        end
    end

    // Scale back to the output fixed-point grid, then apply ReLU and clamp.
    always_comb begin
        shv = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            shv = acc_q[n] >>> W_FRAC;
            if (mode_q && shv[ACC_WIDTH-1]) begin
                shv = '0;
            end
            if (shv > SAT_MAX) begin
                act_d[n] = SAT_MAX[OUT_WIDTH-1:0];
            end else if (shv < SAT_MIN) begin
                act_d[n] = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                act_d[n] = shv[OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            oidx_q      <= '0;
            mode_q      <= 1'b0;
            layer_ready <= 1'b0;
            done        <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                acc_q[n] <= '0;
                res_q[n] <= '0;
            end
        end else begin
            done <= out_hs && (oidx_q == LAST_N);
            if (wt_ok && wt_last) begin
                layer_ready <= 1'b1;
            end
            if (restart) begin
                cnt_q  <= '0;
                oidx_q <= '0;
            end else if (start_go) begin
                cnt_q  <= '0;
                oidx_q <= '0;
                mode_q <= act_mode;
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    acc_q[n] <= '0;
                end
            end else if (in_hs) begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    acc_q[n] <= acc_q[n] + {{(ACC_WIDTH - PW){prod[n][PW-1]}}, prod[n]};
                end
                cnt_q <= (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
            end else if (state_q == ACTIV) begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    res_q[n] <= act_d[n];
                end
                oidx_q <= '0;
            end else if (out_hs) begin
                oidx_q <= (oidx_q == LAST_N) ? '0 : oidx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Scoreboard bench for fc_layer_stream: directed scenarios plus randomized
// inferences compared against a plain-arithmetic model of the layer.
module tb_fc_layer_stream;

    localparam int IW = 26;
    localparam int WW = 16;
    localparam int OW = 29;
    localparam int NN = 2;
    localparam int PC = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 act_mode;
    logic                 start;
    logic                 restart;
    logic                 wt_valid;
    logic [0:0]           wt_neuron;
    logic [1:0]           wt_addr;
    logic signed [WW-1:0] wt_data;
    logic                 wt_last;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic [0:0]           out_index;
    logic                 out_last;
    logic                 layer_ready;
    logic                 busy;
    logic                 done;

    fc_layer_stream #(
        .IN_WIDTH(IW),
        .W_WIDTH(WW),
        .W_FRAC(12),
        .NUM_NEURONS(NN),
        .PREV_COUNT(PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .act_mode(act_mode),
        .start(start),
        .restart(restart),
        .wt_valid(wt_valid),
        .wt_neuron(wt_neuron),
        .wt_addr(wt_addr),
        .wt_data(wt_data),
        .wt_last(wt_last),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_index(out_index),
        .out_last(out_last),
        .layer_ready(layer_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          idx;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   wmodel[NN][PC];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   runs_done = 0;
    bit   hold_ready = 1'b0;
    bit   rand_ready = 1'b0;
    bit   use_gaps = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    task automatic checkOutput(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Every cycle the DUT offers data it must equal the head of the queue; pop on handshake.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
        end
        if (rst === 1'b0 && out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected output: data=%0d index=%0d", out_data, out_index);
            end else begin
                if (out_data !== exp_q[0].data || out_index !== exp_q[0].idx ||
                    out_last !== exp_q[0].last) begin
                    errors++;
                    $display("[TB] FAIL output: got data=%0d index=%0d last=%0d, expected data=%0d index=%0d last=%0d",
                             out_data, out_index, out_last, $signed(exp_q[0].data),
                             exp_q[0].idx, exp_q[0].last);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    function automatic longint modelOut(input int n, input int ins[PC], input bit mode);
        longint acc = 0;
        longint r;
        longint maxo = (longint'(1) <<< (OW - 1)) - 1;
        longint mino = -(longint'(1) <<< (OW - 1));
        for (int i = 0; i < PC; i++) begin
            acc += longint'(ins[i]) * longint'(wmodel[n][i]);
        end
        r = acc >>> 12;
        if (mode && r < 0) r = 0;
        if (r > maxo) r = maxo;
        if (r < mino) r = mino;
        return r;
    endfunction

    task automatic writeWeight(input int n, input int a, input int v, input bit last);
        wt_valid  = 1'b1;
        wt_neuron = 1'(n);
        wt_addr   = 2'(a);
        wt_data   = 16'(v);
        wt_last   = last;
        tick();
        wt_valid  = 1'b0;
        wt_last   = 1'b0;
        wmodel[n][a] = v;
    endtask

    task automatic loadWeights(input int w0[PC], input int w1[PC]);
        for (int i = 0; i < PC; i++) writeWeight(0, i, w0[i], 1'b0);
        for (int i = 0; i < PC; i++) writeWeight(1, i, w1[i], i == PC - 1);
    endtask

    task automatic sendInput(input int v, input bit poke);
        int k = 0;
        if (use_gaps) begin
            repeat ($urandom_range(0, 2)) tick();
        end
        in_valid = 1'b1;
        in_data  = 26'(v);
        if (poke) begin
            wt_valid  = 1'b1;
            wt_neuron = 1'b0;
            wt_addr   = 2'd0;
            wt_data   = 16'sd1234;
            wt_last   = 1'b1;
        end
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        checkOutput("in_ready within bound", in_ready, 1);
        tick();
        in_valid = 1'b0;
        wt_valid = 1'b0;
        wt_last  = 1'b0;
    endtask

    task automatic applyStimulus(input int ins[PC], input bit mode, input bit stall, input bit poke);
        int   k;
        exp_t e;
        for (int n = 0; n < NN; n++) begin
            e.data = OW'(modelOut(n, ins, mode));
            e.idx  = 1'(n);
            e.last = (n == NN - 1);
            exp_q.push_back(e);
        end
        act_mode = mode;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        checkOutput("busy after start", busy, 1);
        for (int i = 0; i < PC; i++) begin
            if (stall && i == PC - 1) hold_ready = 1'b1;
            sendInput(ins[i], poke && i == 0);
        end
        if (stall) begin
            k = 0;
            while (!out_valid && k < 10) begin
                tick();
                k++;
            end
            checkOutput("out_valid appears", out_valid, 1);
            repeat (5) begin
                tick();
                checkOutput("held out_valid", out_valid, 1);
                checkOutput("held out_index", out_index, 0);
            end
            hold_ready = 1'b0;
        end
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        checkOutput("scoreboard drained", exp_q.size(), 0);
        exp_q.delete();
        checkOutput("done pulse", done, 1);
        checkOutput("idle after last output", busy, 0);
        runs_done++;
        tick();
        checkOutput("done single cycle", done, 0);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vin[PC];
        int w0[PC];
        int w1[PC];
        rst = 1'b1; act_mode = 1'b0; start = 1'b0; restart = 1'b0;
        wt_valid = 1'b0; wt_neuron = '0; wt_addr = '0; wt_data = '0; wt_last = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset layer_ready", layer_ready, 0);
        checkOutput("reset out_last", out_last, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset out_index", out_index, 0);

        writeWeight(0, 0, 4096, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start before wt_last ignored", busy, 0);
        checkOutput("layer_ready before wt_last", layer_ready, 0);

        w0 = '{4096, 4096, 4096};
        w1 = '{-4096, 0, 0};
        loadWeights(w0, w1);
        checkOutput("layer_ready after wt_last", layer_ready, 1);

        vin = '{10, 20, 30};
        applyStimulus(vin, 1'b0, 1'b0, 1'b0);
        applyStimulus(vin, 1'b1, 1'b0, 1'b0);
        applyStimulus(vin, 1'b0, 1'b1, 1'b0);
        use_gaps = 1'b1;
        applyStimulus(vin, 1'b0, 1'b0, 1'b0);
        use_gaps = 1'b0;
        applyStimulus(vin, 1'b0, 1'b0, 1'b1);

        act_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        sendInput(7, 1'b0);
        sendInput(9, 1'b0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checkOutput("restart busy", busy, 0);
        checkOutput("restart in_ready", in_ready, 0);
        checkOutput("restart out_valid", out_valid, 0);
        tick();
        checkOutput("restart no done", done_cnt, runs_done);
        vin = '{1, 1, 1};
        applyStimulus(vin, 1'b0, 1'b0, 1'b0);

        w0 = '{32767, 32767, 32767};
        w1 = '{32767, 32767, 32767};
        loadWeights(w0, w1);
        vin = '{33554431, 33554431, 33554431};
        applyStimulus(vin, 1'b0, 1'b0, 1'b0);
        vin = '{-33554432, -33554432, -33554432};
        applyStimulus(vin, 1'b0, 1'b0, 1'b0);
        applyStimulus(vin, 1'b1, 1'b0, 1'b0);

        rand_ready = 1'b1;
        use_gaps   = 1'b1;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < PC; i++) begin
                w0[i] = int'($urandom) >>> 16;
                w1[i] = int'($urandom) >>> 16;
                vin[i] = int'($urandom) >>> 6;
            end
            loadWeights(w0, w1);
            applyStimulus(vin, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        rand_ready = 1'b0;
        tick();
        tick();
        checkOutput("total done pulses", done_cnt, runs_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
